tinyalu_arbiter: RTL

//   Shares one TinyALU between N_REQ requesters. Requesters submit (A, B, op) on a

---
 rtl/tinyalu_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one TinyALU between N_REQ requesters.
// no_op and illegal opcodes complete locally; a watchdog aborts operations whose done never arrives.
module tinyalu_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic                 alu_start,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_op,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_ptr;
    logic [WW-1:0]     r_wdog;
    logic              r_alu_start;
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic [2:0]        r_alu_op;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [15:0]       r_rsp_result;
    logic              r_rsp_err;

    logic              w_found;
    logic [PW-1:0]     w_gnt_idx;
    logic [PW-1:0]     w_cand;
    logic [N_REQ-1:0]  w_gnt_oh;
    logic [N_REQ-1:0]  w_ptr_oh;
    logic [7:0]        w_sel_a;
    logic [7:0]        w_sel_b;
    logic [2:0]        w_sel_op;
    logic              w_legal;
    logic              w_illegal;
    logic              w_accept;
    logic              w_timeout;
    logic [N_REQ-1:0]  w_rsp_mask;
    logic [15:0]       w_rsp_res;
    logic              w_rsp_err;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            w_cand = PW'((32'(r_ptr) + i) % N_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_gnt_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
    assign w_ptr_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << r_ptr;
    assign w_sel_a   = req_a[32'(w_gnt_idx) * 8 +: 8];
    assign w_sel_b   = req_b[32'(w_gnt_idx) * 8 +: 8];
    assign w_sel_op  = req_op[32'(w_gnt_idx) * 3 +: 3];
    assign w_legal   = (w_sel_op >= 3'd1) && (w_sel_op <= 3'd4);
    assign w_illegal = (w_sel_op >= 3'd5);
    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_timeout = (r_state == S_BUSY) && (r_wdog == WW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; done takes priority over the watchdog
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = w_legal ? S_BUSY : S_RESP;
                end
            end
            S_BUSY: begin
                if (alu_done || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Accept pulse and the response payload loaded on entry to RESP
    always_comb begin
        req_ready  = '0;
        w_rsp_mask = w_ptr_oh;
        w_rsp_res  = '0;
        w_rsp_err  = 1'b0;
        if (w_accept) begin
            req_ready = w_gnt_oh;
        end
        if (r_state == S_IDLE) begin
            w_rsp_mask = w_gnt_oh;
            w_rsp_err  = w_illegal;
        end else if (r_state == S_BUSY) begin
            w_rsp_res = alu_done ? alu_result : 16'h0000;
            w_rsp_err = !alu_done;
        end
    end

    // Registered datapath: pointer, ALU drive, watchdog and response bus
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr        <= PW'(N_REQ - 1);
            r_wdog       <= '0;
            r_alu_start  <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_gnt_idx;
            end
            if (w_accept && w_legal) begin
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_op <= w_sel_op;
            end
            r_alu_start <= (w_next == S_BUSY);
            r_wdog      <= ((r_state == S_BUSY) && (w_next == S_BUSY)) ? r_wdog + WW'(1) : '0;
            if (w_next == S_RESP) begin
                r_rsp_valid  <= w_rsp_mask;
                r_rsp_result <= w_rsp_res;
                r_rsp_err    <= w_rsp_err;
            end else begin
                r_rsp_valid  <= '0;
                r_rsp_result <= '0;
                r_rsp_err    <= 1'b0;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign alu_start  = r_alu_start;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;

endmodule
